// File: rtl/icache_param_if.sv
// Fetch/refill handshake bundle for icache_param: CPU fetch, invalidate and memory burst-read channels.
// The cache uses the slave modport; the CPU/memory side uses master.
interface icache_param_if;
  logic        from_cpu_inst_req_valid;
  logic [31:0] from_cpu_inst_req_addr;
  logic        to_cpu_inst_req_ready;
  logic        to_cpu_cache_rsp_valid;
  logic [31:0] to_cpu_cache_rsp_data;
  logic        from_cpu_cache_rsp_ready;
  logic        from_cpu_inv_valid;
  logic        to_cpu_inv_ready;
  logic        to_mem_rd_req_valid;
  logic [31:0] to_mem_rd_req_addr;
  logic        from_mem_rd_req_ready;
  logic        from_mem_rd_rsp_valid;
  logic [31:0] from_mem_rd_rsp_data;
  logic        from_mem_rd_rsp_last;
  logic        to_mem_rd_rsp_ready;

  modport slave (
    input  from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
           from_cpu_inv_valid, from_mem_rd_req_ready, from_mem_rd_rsp_valid,
           from_mem_rd_rsp_data, from_mem_rd_rsp_last,
    output to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
           to_cpu_inv_ready, to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );

  modport master (
    output from_cpu_inst_req_valid, from_cpu_inst_req_addr, from_cpu_cache_rsp_ready,
           from_cpu_inv_valid, from_mem_rd_req_ready, from_mem_rd_rsp_valid,
           from_mem_rd_rsp_data, from_mem_rd_rsp_last,
    input  to_cpu_inst_req_ready, to_cpu_cache_rsp_valid, to_cpu_cache_rsp_data,
           to_cpu_inv_ready, to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_rsp_ready
  );
endinterface

// File: rtl/icache_param.sv
// Parametrised set-associative read-only I-cache with true-LRU replacement and fence.i invalidate.
// Optional ICACHE_PERF_CNT_EN adds hit/miss performance counters.
module icache_param #(
  parameter int unsigned SETS       = 8,
  parameter int unsigned WAYS       = 4,
  parameter int unsigned LINE_WORDS = 8
) (
  input  logic clk,
  input  logic rst,
  icache_param_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - IDX_W - OFF_W;
  localparam int unsigned AGE_W  = $clog2(WAYS);
  localparam int unsigned WSEL_W = $clog2(LINE_WORDS);

  typedef enum logic [6:0] {
    IDLE     = 7'b0000001,
    LOOKUP   = 7'b0000010,
    MISS_REQ = 7'b0000100,
    RECV     = 7'b0001000,
    REFILL   = 7'b0010000,
    RESP     = 7'b0100000,
    INV      = 7'b1000000
  } state_t;

  state_t state, next_state;

  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [31:0]       data_mem [SETS][WAYS][LINE_WORDS];
  logic [WAYS-1:0]   valid    [SETS];
  logic [AGE_W-1:0]  age      [SETS][WAYS];
  logic [31:0]       line_buf [LINE_WORDS];

  logic [31:2]       req_addr;
  logic [WSEL_W-1:0] cnt;
  logic [AGE_W-1:0]  victim;
  logic [31:0]       rsp_data_r;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_word;

  logic              hit;
  logic [AGE_W-1:0]  hit_way;
  logic              found_free;
  logic [AGE_W-1:0]  victim_sel;
  logic              touch;
  logic [AGE_W-1:0]  touch_way;
  logic              accept;
  logic              unused_addr_bits;

  assign req_tag  = req_addr[31 -: TAG_W];
  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_word = req_addr[2 +: WSEL_W];

  assign unused_addr_bits = ^bus.from_cpu_inst_req_addr[1:0];

  assign accept    = (state == IDLE) && !bus.from_cpu_inv_valid && bus.from_cpu_inst_req_valid;
  assign touch     = ((state == LOOKUP) && hit) || (state == REFILL);
  assign touch_way = (state == REFILL) ? victim : hit_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid[req_idx][w] && (tag_mem[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
  end

  // Prefer the lowest invalid way; only a full set falls back to the oldest way.
  always_comb begin
    found_free = 1'b0;
    victim_sel = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found_free && !valid[req_idx][w]) begin
        found_free = 1'b1;
        victim_sel = AGE_W'(w);
      end
    end
    if (!found_free) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (age[req_idx][w] == AGE_W'(WAYS - 1)) victim_sel = AGE_W'(w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state                   = state;
    bus.to_cpu_inst_req_ready    = 1'b0;
    bus.to_cpu_cache_rsp_valid   = 1'b0;
    bus.to_cpu_cache_rsp_data    = '0;
    bus.to_cpu_inv_ready         = 1'b0;
    bus.to_mem_rd_req_valid      = 1'b0;
    bus.to_mem_rd_req_addr       = '0;
    bus.to_mem_rd_rsp_ready      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.from_cpu_inv_valid) begin
          next_state = INV;
        end else begin
          bus.to_cpu_inst_req_ready = 1'b1;
          if (bus.from_cpu_inst_req_valid) next_state = LOOKUP;
        end
      end
      LOOKUP:   next_state = hit ? RESP : MISS_REQ;
      MISS_REQ: begin
        bus.to_mem_rd_req_valid = 1'b1;
        bus.to_mem_rd_req_addr  = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
        if (bus.from_mem_rd_req_ready) next_state = RECV;
      end
      RECV: begin
        bus.to_mem_rd_rsp_ready = 1'b1;
        if (bus.from_mem_rd_rsp_valid && bus.from_mem_rd_rsp_last) next_state = REFILL;
      end
      REFILL:   next_state = RESP;
      RESP: begin
        bus.to_cpu_cache_rsp_valid = 1'b1;
        bus.to_cpu_cache_rsp_data  = rsp_data_r;
        if (bus.from_cpu_cache_rsp_ready) next_state = IDLE;
      end
      INV: begin
        bus.to_cpu_inv_ready = 1'b1;
        next_state           = IDLE;
      end
      default:  next_state = IDLE;
    endcase
  end

  // Valid bits, LRU ages and beat counter carry reset state.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) age[s][w] <= AGE_W'(w);
      end
      cnt <= '0;
    end else begin
      if ((state == LOOKUP) && !hit) valid[req_idx][victim_sel] <= 1'b0;
      if (state == REFILL)           valid[req_idx][victim]     <= 1'b1;
      if (state == INV) begin
        for (int unsigned s = 0; s < SETS; s++) begin
          valid[s] <= '0;
          for (int unsigned w = 0; w < WAYS; w++) age[s][w] <= AGE_W'(w);
        end
      end else if (touch) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == touch_way)
            age[req_idx][w] <= '0;
          else if (age[req_idx][w] < age[req_idx][touch_way])
            age[req_idx][w] <= age[req_idx][w] + 1'b1;
        end
      end
      if ((state == MISS_REQ) && bus.from_mem_rd_req_ready)
        cnt <= '0;
      else if ((state == RECV) && bus.from_mem_rd_rsp_valid)
        cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_addr <= bus.from_cpu_inst_req_addr[31:2];
    if (state == LOOKUP) begin
      victim <= victim_sel;
      if (hit) rsp_data_r <= data_mem[req_idx][hit_way][req_word];
    end
    if ((state == RECV) && bus.from_mem_rd_rsp_valid) line_buf[cnt] <= bus.from_mem_rd_rsp_data;
    if (state == REFILL) begin
      tag_mem[req_idx][victim] <= req_tag;
      for (int unsigned i = 0; i < LINE_WORDS; i++) data_mem[req_idx][victim][i] <= line_buf[i];
      rsp_data_r <= line_buf[req_word];
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hit_cnt  <= '0;
      perf_miss_cnt <= '0;
    end else if (state == LOOKUP) begin
      if (hit) perf_hit_cnt  <= perf_hit_cnt + 32'd1;
      else     perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_param.sv
// Randomized self-checking bench for icache_param against a recency-list cache model.
module tb_icache_param;
  localparam int unsigned SETS       = 8;
  localparam int unsigned WAYS       = 4;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_param_if bus();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] perf_hit_cnt, perf_miss_cnt;
`endif

  icache_param #(.SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .perf_hit_cnt(perf_hit_cnt),
    .perf_miss_cnt(perf_miss_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: per set, resident line numbers ordered most- to least-recently used.
  logic [31:0] res [SETS][WAYS];
  int unsigned res_n [SETS];
  int unsigned m_hits, m_misses;

  task automatic model_clear();
    for (int unsigned s = 0; s < SETS; s++) res_n[s] = 0;
  endtask

  task automatic model_access(input logic [31:0] a, output bit hit);
    logic [31:0] line;
    int unsigned s;
    int pos;
    line = a / LINE_BYTES;
    s    = line % SETS;
    pos  = -1;
    for (int i = 0; i < int'(res_n[s]); i++) if (res[s][i] == line) pos = i;
    hit = (pos >= 0);
    if (!hit) begin
      if (res_n[s] < WAYS) begin
        pos = int'(res_n[s]);
        res_n[s]++;
      end else begin
        pos = WAYS - 1;
      end
    end
    for (int i = pos; i > 0; i--) res[s][i] = res[s][i-1];
    res[s][0] = line;
    if (hit) m_hits++;
    else     m_misses++;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] la, input int unsigned b);
    return (la >> 4) + 32'(b) + {la[11:4], 24'h0};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.to_cpu_inst_req_ready), 32'd1);
    check({tag, "_ctl"}, {27'd0, bus.to_cpu_cache_rsp_valid, bus.to_cpu_inv_ready,
                          bus.to_mem_rd_req_valid, bus.to_mem_rd_rsp_ready, 1'b0}, 32'd0);
    check({tag, "_rsp_data"}, bus.to_cpu_cache_rsp_data, 32'd0);
    check({tag, "_mem_addr"}, bus.to_mem_rd_req_addr, 32'd0);
  endtask

  // Drives one fetch through to completion; abort_beat >= 0 resets the DUT after that many beats.
  task automatic fetch(input logic [31:0] a, input int abort_beat, input int hold,
                       output int mreqs, output int lat, output logic [31:0] data);
    logic [31:0] la;
    int n, k;
    bit done, aborted;
    la = a & ~(LINE_BYTES - 1);
    mreqs = 0; lat = -1; data = '0; done = 0; aborted = 0;
    bus.from_cpu_inst_req_valid = 1'b1;
    bus.from_cpu_inst_req_addr  = a;
    n = 0;
    while (!bus.to_cpu_inst_req_ready && n < 20) begin @(negedge clk); n++; end
    check("accept_ready", 32'(bus.to_cpu_inst_req_ready), 32'd1);
    @(negedge clk);
    bus.from_cpu_inst_req_valid = 1'b0;
    bus.from_cpu_inst_req_addr  = $urandom;
    n = 1;
    while (!done && n < 300) begin
      if (bus.to_mem_rd_req_valid) begin
        mreqs++;
        check("mem_addr", bus.to_mem_rd_req_addr, la);
        repeat ($urandom_range(0, 2)) begin @(negedge clk); n++; end
        bus.from_mem_rd_req_ready = 1'b1;
        @(negedge clk); n++;
        bus.from_mem_rd_req_ready = 1'b0;
        for (int b = 0; b < int'(LINE_WORDS); b++) begin
          if (b == abort_beat) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check_reset_outputs("midrst");
            aborted = 1;
            break;
          end
          repeat ($urandom_range(0, 1)) begin @(negedge clk); n++; end
          bus.from_mem_rd_rsp_valid = 1'b1;
          bus.from_mem_rd_rsp_data  = mem_word(la, b);
          bus.from_mem_rd_rsp_last  = (b == int'(LINE_WORDS) - 1);
          k = 0;
          while (!bus.to_mem_rd_rsp_ready && k < 10) begin @(negedge clk); k++; n++; end
          @(negedge clk); n++;
          bus.from_mem_rd_rsp_valid = 1'b0;
          bus.from_mem_rd_rsp_last  = 1'b0;
        end
        bus.from_mem_rd_rsp_valid = 1'b0;
        bus.from_mem_rd_rsp_last  = 1'b0;
        if (aborted) done = 1;
      end else if (bus.to_cpu_cache_rsp_valid) begin
        done = 1;
        lat  = n + 1;
        data = bus.to_cpu_cache_rsp_data;
      end else begin
        @(negedge clk); n++;
      end
    end
    if (!aborted) begin
      check("rsp_timeout", 32'(done), 32'd1);
      for (int h = 0; h < hold; h++) begin
        bus.from_cpu_inst_req_addr = $urandom;
        @(negedge clk);
        check("hold_valid", 32'(bus.to_cpu_cache_rsp_valid), 32'd1);
        check("hold_data", bus.to_cpu_cache_rsp_data, data);
      end
      bus.from_cpu_cache_rsp_ready = 1'b1;
      @(negedge clk);
      bus.from_cpu_cache_rsp_ready = 1'b0;
      check("idle_after_rsp", {bus.to_cpu_inst_req_ready, bus.to_cpu_cache_rsp_valid}, 32'b10);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input int hold, output int mreqs, output logic [31:0] data);
    bit hit;
    int lat;
    model_access(a, hit);
    fetch(a, -1, hold, mreqs, lat, data);
    check("mem_reqs", 32'(mreqs), hit ? 32'd0 : 32'd1);
    check("rsp_data", data, mem_word(a & ~(LINE_BYTES - 1), (a / 4) % LINE_WORDS));
    if (hit) check("hit_latency", 32'(lat), 32'd3);
  endtask

  task automatic invalidate(input logic [31:0] a);
    bus.from_cpu_inv_valid      = 1'b1;
    bus.from_cpu_inst_req_valid = 1'b1;
    bus.from_cpu_inst_req_addr  = a;
    #1;
    check("inv_blocks_fetch", 32'(bus.to_cpu_inst_req_ready), 32'd0);
    @(negedge clk);
    bus.from_cpu_inv_valid      = 1'b0;
    bus.from_cpu_inst_req_valid = 1'b0;
    check("inv_ready_pulse", 32'(bus.to_cpu_inv_ready), 32'd1);
    @(negedge clk);
    check("inv_ready_drop", {bus.to_cpu_inv_ready, bus.to_cpu_inst_req_ready}, 32'b01);
    model_clear();
  endtask

  initial begin
    int mreqs, lat;
    logic [31:0] data;
    bus.from_cpu_inst_req_valid  = 1'b0;
    bus.from_cpu_inst_req_addr   = '0;
    bus.from_cpu_cache_rsp_ready = 1'b0;
    bus.from_cpu_inv_valid       = 1'b0;
    bus.from_mem_rd_req_ready    = 1'b0;
    bus.from_mem_rd_rsp_valid    = 1'b0;
    bus.from_mem_rd_rsp_data     = '0;
    bus.from_mem_rd_rsp_last     = 1'b0;
    m_hits = 0; m_misses = 0;
    model_clear();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Cold miss then hit on the same line.
    do_fetch(32'h0000_1004, 0, mreqs, data);
    check("cold_data", data, 32'h0000_0101);
    check("cold_reqs", 32'(mreqs), 32'd1);
    do_fetch(32'h0000_1004, 0, mreqs, data);
    check("refetch_reqs", 32'(mreqs), 32'd0);

    // Invalidate beats a simultaneous fetch; cached line must miss afterwards.
    invalidate(32'h0000_1004);
    do_fetch(32'h0000_1004, 0, mreqs, data);
    check("inv_then_miss", 32'(mreqs), 32'd1);
    invalidate(32'h0);

    // LRU eviction in set 0.
    do_fetch(32'h0, 0, mreqs, data);
    do_fetch(32'h100, 0, mreqs, data);
    do_fetch(32'h200, 0, mreqs, data);
    do_fetch(32'h300, 0, mreqs, data);
    do_fetch(32'h0, 0, mreqs, data);
    check("lru_touch_hit", 32'(mreqs), 32'd0);
    do_fetch(32'h400, 0, mreqs, data);
    do_fetch(32'h0, 0, mreqs, data);
    check("lru_keep_0", 32'(mreqs), 32'd0);
    do_fetch(32'h100, 0, mreqs, data);
    check("lru_evict_100", 32'(mreqs), 32'd1);

    // Response held while address wiggles.
    do_fetch(32'h0000_0208, 5, mreqs, data);

    // Reset in the middle of a refill.
    fetch(32'h0000_2008, 3, 0, mreqs, lat, data);
    model_clear();
    m_hits = 0; m_misses = 0;
    do_fetch(32'h0000_2008, 0, mreqs, data);
    check("midrst_refetch_miss", 32'(mreqs), 32'd1);

    // Random traffic: six tags per set forces evictions with four ways.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ((32'($urandom_range(0, 5)) * SETS + 32'($urandom_range(0, SETS - 1))) * LINE_BYTES)
          + 32'($urandom_range(0, LINE_WORDS - 1)) * 4;
      if ($urandom_range(0, 49) == 0) invalidate(a);
      do_fetch(a, $urandom_range(0, 2), mreqs, data);
    end

`ifdef ICACHE_PERF_CNT_EN
    check("perf_hits", perf_hit_cnt, 32'(m_hits));
    check("perf_misses", perf_miss_cnt, 32'(m_misses));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
